// File: rtl/bp_update_queue_pkg.sv
// ============================================================================
// Module      : bp_update_queue_pkg
// Description : Shared types and constants for the branch-outcome update queue.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package bp_update_queue_pkg;

    localparam int BPUQ_DEPTH = 8;
    localparam int BPUQ_IDX_W = 6;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } TWO_BIT_COUNTER;

    // Status flags of one entry; the predictor index is kept in a parallel
    // array so its width can follow the IDX_W module parameter.
    typedef struct packed {
        logic valid;
        logic resolved;
        logic taken;
    } BPUQ_ENTRY;

endpackage

`default_nettype wire

// File: rtl/bp_update_queue_ghr.sv
// ============================================================================
// Module      : bpuq_ghr
// Description : Global history shift register; shifts in one outcome per
//               enabled cycle. Only used when BPUQ_GSHARE_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bpuq_ghr
    import bp_update_queue_pkg::*;
#(
    parameter int WIDTH = BPUQ_IDX_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_shift_en,
    input  logic             i_shift_in,
    output logic [WIDTH-1:0] o_ghr
);

    logic [WIDTH-1:0] ghr_q;
    logic [WIDTH-1:0] ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (i_shift_en) begin
            ghr_d = {ghr_q[WIDTH-2:0], i_shift_in};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign o_ghr = ghr_q;

endmodule

`default_nettype wire

// File: rtl/bp_update_queue.sv
// ============================================================================
// Module      : bp_update_queue
// Description : In-order branch-outcome buffer feeding predictor counter-table
//               updates; out-of-order resolve, oldest-first drain, squash.
//               Define BPUQ_GSHARE_EN to hash the update index with history.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module bp_update_queue
    import bp_update_queue_pkg::*;
#(
    parameter int DEPTH = BPUQ_DEPTH,
    parameter int IDX_W = BPUQ_IDX_W,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alloc_valid,
    input  logic [IDX_W-1:0] alloc_pc_idx,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             resolve_valid,
    input  logic [TAG_W-1:0] resolve_tag,
    input  logic             resolve_taken,
    input  logic             resolve_mispredict,
    output logic             upd_wr_en,
    output logic             upd_taken,
    output logic [IDX_W-1:0] upd_idx,
    output logic [TAG_W:0]   count
);

    localparam logic [TAG_W:0]   FULL_COUNT = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE    = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE    = TAG_W'(1);

    BPUQ_ENTRY        entry_q  [DEPTH];
    BPUQ_ENTRY        entry_d  [DEPTH];
    logic [IDX_W-1:0] pc_idx_q [DEPTH];
    logic [IDX_W-1:0] pc_idx_d [DEPTH];
    logic [TAG_W-1:0] head_q, head_d;
    logic [TAG_W-1:0] tail_q, tail_d;
    logic [TAG_W:0]   count_q, count_d;

    logic             w_drain;
    logic             w_resolve_hit;
    logic             w_squash;
    logic             w_alloc_fire;
    logic [TAG_W-1:0] w_res_off;

    always_comb begin
        logic [TAG_W-1:0] ent_off;

        w_drain       = entry_q[head_q].valid & entry_q[head_q].resolved;
        w_resolve_hit = resolve_valid & entry_q[resolve_tag].valid;
        w_squash      = w_resolve_hit & resolve_mispredict;
        w_alloc_fire  = alloc_valid & alloc_ready & ~w_squash;
        w_res_off     = resolve_tag - head_q;
        ent_off       = '0;

        entry_d  = entry_q;
        pc_idx_d = pc_idx_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (w_alloc_fire) begin
            entry_d[tail_q]  = '{valid: 1'b1, resolved: 1'b0, taken: 1'b0};
            pc_idx_d[tail_q] = alloc_pc_idx;
            tail_d           = tail_q + TAG_ONE;
            count_d          = count_q + CNT_ONE;
        end

        if (w_resolve_hit) begin
            entry_d[resolve_tag].resolved = 1'b1;
            entry_d[resolve_tag].taken    = resolve_taken;
        end

        // Age is measured as distance from head, so wrap needs no special case.
        if (w_squash) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_off = TAG_W'(i) - head_q;
                if ((ent_off > w_res_off) && ({1'b0, ent_off} < count_q)) begin
                    entry_d[i].valid = 1'b0;
                end
            end
            tail_d  = resolve_tag + TAG_ONE;
            count_d = {1'b0, w_res_off} + CNT_ONE;
        end

        if (w_drain) begin
            entry_d[head_q].valid = 1'b0;
            head_d                = head_q + TAG_ONE;
            count_d               = count_d - CNT_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i]  <= '0;
                pc_idx_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            entry_q  <= entry_d;
            pc_idx_q <= pc_idx_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    assign alloc_ready = (count_q != FULL_COUNT);
    assign alloc_tag   = tail_q;
    assign count       = count_q;
    assign upd_wr_en   = w_drain;
    assign upd_taken   = entry_q[head_q].taken;

`ifdef BPUQ_GSHARE_EN
    logic [IDX_W-1:0] w_ghr;

    bpuq_ghr #(
        .WIDTH (IDX_W)
    ) u_ghr (
        .clock      (clock),
        .reset      (reset),
        .i_shift_en (w_drain),
        .i_shift_in (upd_taken),
        .o_ghr      (w_ghr)
    );

    assign upd_idx = pc_idx_q[head_q] ^ w_ghr;
`else
    assign upd_idx = pc_idx_q[head_q];
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_update_queue.sv
// ============================================================================
// Module      : tb_bp_update_queue
// Description : Self-checking bench for bp_update_queue (directed + random
//               against a queue-based model); honours BPUQ_GSHARE_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bp_update_queue;

    localparam int DEPTH = 8;
    localparam int IDX_W = 6;
    localparam int TAG_W = 3;
`ifdef BPUQ_GSHARE_EN
    localparam bit GSHARE = 1'b1;
`else
    localparam bit GSHARE = 1'b0;
`endif

    logic             clock;
    logic             reset;
    logic             alloc_valid;
    logic [IDX_W-1:0] alloc_pc_idx;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             resolve_valid;
    logic [TAG_W-1:0] resolve_tag;
    logic             resolve_taken;
    logic             resolve_mispredict;
    logic             upd_wr_en;
    logic             upd_taken;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W:0]   count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int               tag;
        logic [IDX_W-1:0] idx;
        bit               res;
        bit               tk;
    } m_ent_t;

    m_ent_t           mq[$];
    int               m_tail;
    logic [IDX_W-1:0] m_ghr;

    bp_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .alloc_valid        (alloc_valid),
        .alloc_pc_idx       (alloc_pc_idx),
        .alloc_ready        (alloc_ready),
        .alloc_tag          (alloc_tag),
        .resolve_valid      (resolve_valid),
        .resolve_tag        (resolve_tag),
        .resolve_taken      (resolve_taken),
        .resolve_mispredict (resolve_mispredict),
        .upd_wr_en          (upd_wr_en),
        .upd_taken          (upd_taken),
        .upd_idx            (upd_idx),
        .count              (count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    function automatic logic [IDX_W-1:0] exp_idx(input logic [IDX_W-1:0] idx,
                                                 input logic [IDX_W-1:0] h);
        return GSHARE ? (idx ^ h) : idx;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid        = 1'b0;
        alloc_pc_idx       = '0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_taken      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        mq.delete();
        m_tail = 0;
        m_ghr  = '0;
    endtask

    task automatic alloc_one(input logic [IDX_W-1:0] idx);
        alloc_valid  = 1'b1;
        alloc_pc_idx = idx;
        tick();
        alloc_valid  = 1'b0;
    endtask

    task automatic resolve_one(input int tag, input bit tk, input bit mis);
        resolve_valid      = 1'b1;
        resolve_tag        = TAG_W'(tag);
        resolve_taken      = tk;
        resolve_mispredict = mis;
        tick();
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
    endtask

    // Program-order list of live branches: the head is mq[0].
    task automatic model_step();
        int     p;
        bit     dr;
        bit     dtk;
        m_ent_t e;
        p   = -1;
        dr  = (mq.size() > 0) && mq[0].res;
        dtk = dr ? mq[0].tk : 1'b0;
        if (resolve_valid) begin
            for (int k = 0; k < mq.size(); k++) begin
                if (mq[k].tag == int'(resolve_tag)) p = k;
            end
        end
        if (p >= 0) begin
            e     = mq[p];
            e.res = 1'b1;
            e.tk  = resolve_taken;
            mq[p] = e;
        end
        if (p >= 0 && resolve_mispredict) begin
            while (mq.size() > p + 1) void'(mq.pop_back());
            m_tail = (int'(resolve_tag) + 1) % DEPTH;
        end else if (alloc_valid && mq.size() < DEPTH) begin
            e.tag = m_tail;
            e.idx = alloc_pc_idx;
            e.res = 1'b0;
            e.tk  = 1'b0;
            mq.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
        if (dr) begin
            void'(mq.pop_front());
            m_ghr = {m_ghr[IDX_W-2:0], dtk};
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (upd_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", upd_wr_en); end
        checks++; if (upd_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b expected 0", upd_taken); end
        checks++; if (upd_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", upd_idx); end
        checks++; if (alloc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", alloc_ready); end
        checks++; if (alloc_tag !== '0) begin errors++; $display("FAIL reset_tag: got %0d expected 0", alloc_tag); end
        checks++; if (count !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    endtask

    task automatic test_in_order_drain();
        do_reset();
        checks++; if (alloc_tag !== 3'd0) begin errors++; $display("FAIL order_tag0: got %0d expected 0", alloc_tag); end
        alloc_one(6'd5);
        checks++; if (alloc_tag !== 3'd1) begin errors++; $display("FAIL order_tag1: got %0d expected 1", alloc_tag); end
        alloc_one(6'd9);
        alloc_one(6'd12);
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL order_count: got %0d expected 3", count); end
        resolve_one(1, 1'b1, 1'b0);
        checks++; if (upd_wr_en !== 1'b0) begin errors++; $display("FAIL order_young_blocked: got %b expected 0", upd_wr_en); end
        resolve_one(0, 1'b0, 1'b0);
        checks++; if (upd_wr_en !== 1'b1 || upd_taken !== 1'b0 || upd_idx !== exp_idx(6'd5, 6'd0)) begin
            errors++; $display("FAIL order_drain0: got wr=%b tk=%b idx=%0d expected wr=1 tk=0 idx=%0d", upd_wr_en, upd_taken, upd_idx, exp_idx(6'd5, 6'd0));
        end
        tick();
        checks++; if (upd_wr_en !== 1'b1 || upd_taken !== 1'b1 || upd_idx !== exp_idx(6'd9, 6'd0)) begin
            errors++; $display("FAIL order_drain1: got wr=%b tk=%b idx=%0d expected wr=1 tk=1 idx=%0d", upd_wr_en, upd_taken, upd_idx, exp_idx(6'd9, 6'd0));
        end
        tick();
        checks++; if (upd_wr_en !== 1'b0 || count !== 4'd1) begin
            errors++; $display("FAIL order_after: got wr=%b count=%0d expected wr=0 count=1", upd_wr_en, count);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc_one(IDX_W'(20 + i));
        checks++; if (alloc_ready !== 1'b0 || count !== 4'd8) begin
            errors++; $display("FAIL full_state: got ready=%b count=%0d expected ready=0 count=8", alloc_ready, count);
        end
        alloc_one(6'd63);
        checks++; if (count !== 4'd8 || alloc_tag !== 3'd0) begin
            errors++; $display("FAIL full_alloc_ignored: got count=%0d tag=%0d expected count=8 tag=0", count, alloc_tag);
        end
        resolve_one(0, 1'b1, 1'b0);
        checks++; if (upd_wr_en !== 1'b1 || upd_idx !== exp_idx(6'd20, 6'd0) || alloc_ready !== 1'b0) begin
            errors++; $display("FAIL full_drain: got wr=%b idx=%0d ready=%b expected wr=1 idx=%0d ready=0", upd_wr_en, upd_idx, alloc_ready, exp_idx(6'd20, 6'd0));
        end
        tick();
        checks++; if (count !== 4'd7 || alloc_ready !== 1'b1 || alloc_tag !== 3'd0 || upd_wr_en !== 1'b0) begin
            errors++; $display("FAIL full_after_drain: got count=%0d ready=%b tag=%0d wr=%b expected 7 1 0 0", count, alloc_ready, alloc_tag, upd_wr_en);
        end
        alloc_one(6'd40);
        checks++; if (count !== 4'd8 || alloc_tag !== 3'd1) begin
            errors++; $display("FAIL full_wrap_alloc: got count=%0d tag=%0d expected count=8 tag=1", count, alloc_tag);
        end
    endtask

    task automatic test_mispredict();
        logic [IDX_W-1:0] h;
        h = '0;
        do_reset();
        for (int i = 0; i < 6; i++) alloc_one(IDX_W'(10 + i));
        resolve_one(2, 1'b1, 1'b1);
        checks++; if (count !== 4'd3 || alloc_tag !== 3'd3) begin
            errors++; $display("FAIL mis_squash: got count=%0d tag=%0d expected count=3 tag=3", count, alloc_tag);
        end
        for (int t = 3; t < 6; t++) begin
            resolve_one(t, 1'b1, 1'b0);
            checks++; if (count !== 4'd3 || upd_wr_en !== 1'b0) begin
                errors++; $display("FAIL mis_dead_resolve: got count=%0d wr=%b expected count=3 wr=0", count, upd_wr_en);
            end
        end
        resolve_valid = 1'b1; resolve_tag = 3'd0; resolve_taken = 1'b1;
        tick();
        checks++; if (upd_wr_en !== 1'b1 || upd_taken !== 1'b1 || upd_idx !== exp_idx(6'd10, h)) begin
            errors++; $display("FAIL mis_drain0: got wr=%b tk=%b idx=%0d expected 1 1 %0d", upd_wr_en, upd_taken, upd_idx, exp_idx(6'd10, h));
        end
        h = {h[IDX_W-2:0], 1'b1};
        resolve_tag = 3'd1; resolve_taken = 1'b0;
        tick();
        resolve_valid = 1'b0;
        checks++; if (upd_wr_en !== 1'b1 || upd_taken !== 1'b0 || upd_idx !== exp_idx(6'd11, h)) begin
            errors++; $display("FAIL mis_drain1: got wr=%b tk=%b idx=%0d expected 1 0 %0d", upd_wr_en, upd_taken, upd_idx, exp_idx(6'd11, h));
        end
        h = {h[IDX_W-2:0], 1'b0};
        tick();
        checks++; if (upd_wr_en !== 1'b1 || upd_taken !== 1'b1 || upd_idx !== exp_idx(6'd12, h)) begin
            errors++; $display("FAIL mis_drain2: got wr=%b tk=%b idx=%0d expected 1 1 %0d", upd_wr_en, upd_taken, upd_idx, exp_idx(6'd12, h));
        end
        tick();
        checks++; if (upd_wr_en !== 1'b0 || count !== 4'd0) begin
            errors++; $display("FAIL mis_empty: got wr=%b count=%0d expected 0 0", upd_wr_en, count);
        end
    endtask

    task automatic test_mispredict_alloc();
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(IDX_W'(1 + i));
        alloc_valid = 1'b1; alloc_pc_idx = 6'd33;
        resolve_valid = 1'b1; resolve_tag = 3'd1; resolve_taken = 1'b1; resolve_mispredict = 1'b1;
        checks++; if (alloc_tag !== 3'd4) begin errors++; $display("FAIL misalloc_pre_tag: got %0d expected 4", alloc_tag); end
        tick();
        resolve_valid = 1'b0; resolve_mispredict = 1'b0;
        checks++; if (alloc_tag !== 3'd2 || count !== 4'd2) begin
            errors++; $display("FAIL misalloc_dropped: got tag=%0d count=%0d expected tag=2 count=2", alloc_tag, count);
        end
        tick();
        alloc_valid = 1'b0;
        checks++; if (alloc_tag !== 3'd3 || count !== 4'd3) begin
            errors++; $display("FAIL misalloc_retry: got tag=%0d count=%0d expected tag=3 count=3", alloc_tag, count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) alloc_one(IDX_W'(50 + i));
        for (int t = 3; t >= 0; t--) resolve_one(t, 1'b1, 1'b0);
        checks++; if (upd_wr_en !== 1'b1) begin errors++; $display("FAIL rmid_pending: got wr=%b expected 1", upd_wr_en); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (upd_wr_en !== 1'b0 || count !== '0 || alloc_tag !== '0 || alloc_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_cleared: got wr=%b count=%0d tag=%0d ready=%b expected 0 0 0 1", upd_wr_en, count, alloc_tag, alloc_ready);
        end
        tick();
        checks++; if (upd_wr_en !== 1'b0) begin errors++; $display("FAIL rmid_quiet: got wr=%b expected 0", upd_wr_en); end
    endtask

    task automatic test_gshare();
        do_reset();
        alloc_one(6'd3);
        alloc_one(6'd3);
        resolve_one(1, 1'b1, 1'b0);
        resolve_one(0, 1'b1, 1'b0);
        checks++; if (upd_wr_en !== 1'b1 || upd_idx !== exp_idx(6'd3, 6'd0)) begin
            errors++; $display("FAIL gshare_first: got wr=%b idx=%0d expected 1 %0d", upd_wr_en, upd_idx, exp_idx(6'd3, 6'd0));
        end
        tick();
        checks++; if (upd_wr_en !== 1'b1 || upd_idx !== exp_idx(6'd3, 6'd1)) begin
            errors++; $display("FAIL gshare_second: got wr=%b idx=%0d expected 1 %0d", upd_wr_en, upd_idx, exp_idx(6'd3, 6'd1));
        end
    endtask

    task automatic test_random();
        bit exp_wr;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            alloc_valid  = ($urandom_range(0, 99) < 60);
            alloc_pc_idx = IDX_W'($urandom);
            resolve_valid = ($urandom_range(0, 99) < 55);
            if (mq.size() > 0 && $urandom_range(0, 99) < 80)
                resolve_tag = TAG_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
            else
                resolve_tag = TAG_W'($urandom);
            resolve_taken      = 1'($urandom);
            resolve_mispredict = ($urandom_range(0, 99) < 8);

            exp_wr = (mq.size() > 0) && mq[0].res;
            checks++; if (alloc_ready !== (mq.size() < DEPTH) || alloc_tag !== TAG_W'(m_tail) || count !== (TAG_W+1)'(mq.size())) begin
                errors++; $display("FAIL rand_state cyc %0d: got ready=%b tag=%0d count=%0d expected %b %0d %0d",
                                   cyc, alloc_ready, alloc_tag, count, (mq.size() < DEPTH), m_tail, mq.size());
            end
            checks++; if (upd_wr_en !== exp_wr) begin
                errors++; $display("FAIL rand_wr_en cyc %0d: got %b expected %b", cyc, upd_wr_en, exp_wr);
            end
            if (exp_wr) begin
                checks++; if (upd_taken !== mq[0].tk || upd_idx !== exp_idx(mq[0].idx, m_ghr)) begin
                    errors++; $display("FAIL rand_update cyc %0d: got tk=%b idx=%0d expected tk=%b idx=%0d",
                                       cyc, upd_taken, upd_idx, mq[0].tk, exp_idx(mq[0].idx, m_ghr));
                end
            end
            tick();
            model_step();
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_in_order_drain();
        test_full();
        test_mispredict();
        test_mispredict_alloc();
        test_reset_mid();
        test_gshare();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
